hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
// - Hazard and forwarding control for the 5-stage pipeline. Drives the stall and condep inputs of the ID/EX register
//   and the 2-bit forwarding selects (fwda/fwdb) that travel with the instruction into EX.
// - Holds an internal shadow of the EX and MEM stage destination info, so it tracks in-flight writers by itself.
// - Also keeps saturating stall and flush event counters for performance debug.
// PARAMETERS
// - CNT_W   16   width of the stall_cnt and flush_cnt event counters
// PORTS
// - Clk        in   1      clock; all state updates on the rising edge
// - Clrn       in   1      reset; synchronous, active-low
// - En         in   1      pipeline advance enable, same signal as the pipeline registers' En
// - id_rs      in   5      rs field of the instruction in ID
// - id_rt      in   5      rt field of the instruction in ID
// - id_use_rs  in   1      ID instruction reads rs
// - id_use_rt  in   1      ID instruction reads rt
// - id_wreg    in   1      ID instruction writes the register file
// - id_m2reg   in   1      ID instruction is a load (result comes from memory)
// - id_rd      in   5      destination register of the ID instruction (already muxed rd/rt)
// - id_branch  in   1      ID instruction is a branch or jump
// - ex_taken   in   1      EX datapath reports branch condition true (valid only when the EX slot holds a branch)
// - stall      out  1      load-use stall: freeze PC and IF/ID, insert bubble into ID/EX
// - condep     out  1      control-dependency flush: kill the instructions in IF/ID and ID
// - pc_en      out  1      PC write enable = ~stall
// - ifid_en    out  1      IF/ID write enable = ~stall
// - fwda       out  2      rs operand source: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
// - fwdb       out  2      rt operand source, same encoding as fwda
// - stall_cnt  out  CNT_W  number of stall cycles, saturating
// - flush_cnt  out  CNT_W  number of condep cycles, saturating
// BEHAVIOUR
// - Shadow state: ex_{wreg,m2reg,rd,branch} and mem_{wreg,m2reg,rd}.
// - Reset (Clrn=0 at the edge) clears all shadow bits and both counters.
//   Consequently stall=0, condep=0, fwda=fwdb=00, pc_en=ifid_en=1 in the cycle after reset.
// - Shadow update, on an edge with En=1:
//   - mem_* <= ex_*.
//   - If stall or condep, ex_* <= 0 (bubble); otherwise ex_* <= id_*.
//   - With En=0 all shadow state and counters hold; outputs are still evaluated from the held state.
// - Outputs are combinational from the shadow state and the ID inputs (zero latency, same cycle).
// - A writer matches register r when its wreg=1, its rd!=0, and its rd==r. Register 0 never forwards and never stalls.
// - stall = ex_wreg & ex_m2reg & ex_rd!=0 & ((id_use_rs & ex_rd==id_rs) | (id_use_rt & ex_rd==id_rt)) & ~condep.
// - condep = ex_branch & ex_taken. It is asserted for exactly the one cycle the taken branch is in EX.
// - Priority: condep over stall. Both cannot arise together (a branch in EX is never a load);
//   if they ever do, stall is forced 0 so the branch target loads.
// - Forwarding, fwda (fwdb is identical using id_rt):
//   - EX match and !ex_m2reg -> 01.
//   - Else MEM match and !mem_m2reg -> 10.
//   - Else MEM match and mem_m2reg -> 11.
//   - Else 00.
//   - EX takes priority over MEM when both stages write the same register.
//   - An EX load match produces stall, not forwarding; fwda is then don't-care, because that ID/EX load is cleared.
// - Counters, on an edge with En=1:
//   - stall_cnt += 1 when stall=1; flush_cnt += 1 when condep=1.
//   - Each counter holds at 2^CNT_W-1 (no wrap).
// - Reset mid-stall: the shadow clears, so stall drops on the next cycle. No stall state persists across reset.
// TESTING
// - Reset then idle -> stall=0, condep=0, fwda=fwdb=00, pc_en=ifid_en=1, counters 0.
// - add r3 in ID, then add using rs=r3 -> fwda=01 on the 2nd cycle; after a NOP between them -> fwda=10.
// - lw r5 followed by add reading rt=r5:
//   -> stall=1 for exactly 1 cycle, pc_en=0, stall_cnt=1;
//   -> next cycle fwdb=11 (load now in MEM); ex_* shows the bubble.
// - Writer to r0 (id_rd=0, id_wreg=1), then a reader of r0 -> fwda=00, stall=0.
// - Branch in ID, then ex_taken=1 on the next cycle -> condep=1 for 1 cycle, flush_cnt=1;
//   the following cycle ex_* is a bubble (ex_branch=0, condep=0).
// - En=0 for 3 cycles while lw is in EX and a dependent instruction is in ID
//   -> stall stays 1, counters frozen, shadow unchanged.
// - CNT_W=2 with 5 stall events -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding control for a 5-stage pipeline.
// Tracks EX/MEM destination info internally, produces load-use stall,
// taken-branch flush (condep), operand forwarding selects and saturating
// stall/flush event counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             En,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [4:0]       id_rd,
  input  logic             id_branch,
  input  logic             ex_taken,
  output logic             stall,
  output logic             condep,
  output logic             pc_en,
  output logic             ifid_en,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Shadow of the instructions currently in EX and MEM
  logic             ex_wreg_reg, ex_m2reg_reg, ex_branch_reg;
  logic [4:0]       ex_rd_reg;
  logic             mem_wreg_reg, mem_m2reg_reg;
  logic [4:0]       mem_rd_reg;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  // Per-operand view: index 0 is rs (fwda), index 1 is rt (fwdb)
  logic [4:0] src_reg_num [2];
  logic       src_used    [2];
  logic       ex_hit      [2];
  logic       mem_hit     [2];
  logic [1:0] fwd_sel     [2];
  logic       load_hit    [2];

  assign src_reg_num[0] = id_rs;
  assign src_reg_num[1] = id_rt;
  assign src_used[0]    = id_use_rs;
  assign src_used[1]    = id_use_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // A writer matches when it writes a non-zero register equal to the source
      assign ex_hit[gi]  = ex_wreg_reg  && (ex_rd_reg  != 5'd0) && (ex_rd_reg  == src_reg_num[gi]);
      assign mem_hit[gi] = mem_wreg_reg && (mem_rd_reg != 5'd0) && (mem_rd_reg == src_reg_num[gi]);
      // Load in EX feeding this operand cannot be forwarded in time
      assign load_hit[gi] = src_used[gi] && ex_hit[gi] && ex_m2reg_reg;

      // Forward select; the youngest writer (EX) wins over MEM
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (ex_hit[gi] && !ex_m2reg_reg)
          fwd_sel[gi] = 2'b01;
        else if (mem_hit[gi] && !mem_m2reg_reg)
          fwd_sel[gi] = 2'b10;
        else if (mem_hit[gi] && mem_m2reg_reg)
          fwd_sel[gi] = 2'b11;
      end
    end
  endgenerate

  // Flush beats stall so a taken branch always redirects the PC
  always_comb begin
    condep  = ex_branch_reg & ex_taken;
    stall   = (load_hit[0] | load_hit[1]) & ~condep;
    pc_en   = ~stall;
    ifid_en = ~stall;
    fwda    = fwd_sel[0];
    fwdb    = fwd_sel[1];
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

  // Advance shadow pipeline (bubble on stall/flush) and count events
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      ex_wreg_reg   <= 1'b0;
      ex_m2reg_reg  <= 1'b0;
      ex_rd_reg     <= 5'd0;
      ex_branch_reg <= 1'b0;
      mem_wreg_reg  <= 1'b0;
      mem_m2reg_reg <= 1'b0;
      mem_rd_reg    <= 5'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (En) begin
      mem_wreg_reg  <= ex_wreg_reg;
      mem_m2reg_reg <= ex_m2reg_reg;
      mem_rd_reg    <= ex_rd_reg;
      if (stall || condep) begin
        ex_wreg_reg   <= 1'b0;
        ex_m2reg_reg  <= 1'b0;
        ex_rd_reg     <= 5'd0;
        ex_branch_reg <= 1'b0;
      end else begin
        ex_wreg_reg   <= id_wreg;
        ex_m2reg_reg  <= id_m2reg;
        ex_rd_reg     <= id_rd;
        ex_branch_reg <= id_branch;
      end
      if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (condep && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

endmodule
